rr_priority_arbiter: RTL
========================

// Module: rr_priority_arbiter
// PURPOSE
//  Parametrised N-way arbiter; successor to the combinational lowest-index priority encoder.
//  Selects one of N requesters per mode (fixed lowest-index or round-robin).
//  Registers the grant and holds it stable until a valid/ready accept.
//  Used ahead of shared resources (issue ports, memory/bus masters).
// PARAMETERS
//  N    4                 number of requesters, N >= 1
//  IDW  max(1,$clog2(N))  localparam; width of gnt_idx and rr_ptr
// PORTS
//  clk         in   1    single clock, rising edge
//  rst_n       in   1    asynchronous active-low reset
//  req         in   N    request vector; requester holds req[i] until its grant is accepted
//  mode        in   1    0 = fixed priority (index 0 highest), 1 = round-robin
//  gnt_ready   in   1    downstream accepts current grant this cycle
//  req_last    in   1    ARB_LOCK_EN only: accepted beat is the last of a locked burst
//  gnt_valid   out  1    a grant is presented
//  gnt_onehot  out  N    one-hot grant; all zero when gnt_valid=0
//  gnt_idx     out  IDW  binary index of the grant; 0 when gnt_valid=0
// BEHAVIOUR
//  Reset (async assert, sync release): gnt_valid=0, gnt_onehot=0, gnt_idx=0, rr_ptr=0,
//   state=IDLE. Effect is immediate, including mid-grant; the pending grant is discarded.
//  FSM IDLE:
//   - If |req, arbitrate, register the winner and go to GRANT; otherwise stay in IDLE.
//   - Latency: req sampled at edge k gives gnt_valid=1 after edge k (1 cycle).
//  FSM GRANT:
//   - gnt_valid=1. gnt_onehot and gnt_idx stay stable while gnt_ready=0.
//   - New or dropped req bits never alter a presented grant.
//   - Dropping the granted req before accept is a protocol violation; the bench asserts on it.
//  Accept = gnt_valid & gnt_ready.
//   - On accept, set rr_ptr = (gnt_idx+1) mod N in both modes.
//   - On accept, re-arbitrate the same cycle using req_eff = req & ~gnt_onehot.
//   - If req_eff != 0, load the new winner and stay in GRANT (back-to-back, no bubble).
//   - If req_eff == 0, go to IDLE (gnt_valid=0 next cycle).
//   - A sole requester that re-asserts therefore sees one idle cycle between grants.
//  Arbitration:
//   - mode=0: lowest set index of the candidate vector.
//   - mode=1: first set index scanning rr_ptr, rr_ptr+1, ... modulo N (wrap-around).
//   - mode is sampled only at an arbitration instant; a change never alters a held grant.
//  Widths: gnt_idx is zero-extended to IDW. rr_ptr wraps N-1 -> 0 (non-power-of-2 N handled).
//  N=1: rr_ptr is constant 0; the grant is req[0] through the same handshake.
// CONFIGURATION
//  ARB_LOCK_EN defined:
//   - Accept with req_last=0 keeps the same grant (no re-arbitration) and leaves rr_ptr unchanged.
//   - Accept with req_last=1 behaves as a normal accept.
//  ARB_LOCK_EN undefined:
//   - req_last port is present but ignored; every accept is a normal accept.
// TESTING
//  T1 reset: rst_n=0 while GRANT idx2 -> outputs 0 asynchronously; after release, req=0001 -> idx0.
//  T2 fixed: mode=0, req=1010, gnt_ready=1 -> idx1, then idx3 next cycle, then gnt_valid=0.
//  T3 round-robin: mode=1, req=1111 held, gnt_ready=1 -> idx 0,1,2,3,0,1 on consecutive cycles.
//  T4 backpressure: req=0100, gnt_ready=0 for 5 cycles, req[0] raised at cycle 2
//     -> gnt_onehot=0100, gnt_idx=2 stable; after accept -> idx0.
//  T5 lock (ARB_LOCK_EN): req=0101, grant idx2, req_last=0,0,1 on three accepts
//     -> idx2 for all three, then idx0.
//  T6 sole requester: mode=1, req=1000 re-asserted after each accept
//     -> idx3, gnt_valid=0 for one cycle, idx3 again; rr_ptr=0 after each accept.

Source files
------------

// File: rtl/rr_priority_arbiter.sv
// N-way arbiter with fixed-priority or round-robin selection and a registered grant held until accepted.
// Optional ARB_LOCK_EN: accepts with req_last=0 keep the current grant so a multi-beat burst stays locked.
module rr_priority_arbiter #(
  parameter  int N   = 4,
  localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic           mode,
  input  logic           gnt_ready,
  input  logic           req_last,
  output logic           gnt_valid,
  output logic [N-1:0]   gnt_onehot,
  output logic [IDW-1:0] gnt_idx
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] gnt_idx_q, gnt_idx_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] next_ptr;
  logic [N-1:0]   cand;
  logic           accept;
  logic           release_gnt;

  // Scan downwards so the last hit is the first candidate in priority order.
  function automatic logic [IDW-1:0] arb_pick(input logic [N-1:0] c, input logic rr,
                                              input logic [IDW-1:0] ptr);
    logic [IDW-1:0] win;
    int j;
    win = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rr) begin
        j = int'(ptr) + k;
        if (j >= N) j = j - N;
      end else begin
        j = k;
      end
      if (c[j]) win = IDW'(j);
    end
    return win;
  endfunction

  assign gnt_valid  = (state_q == GRANT);
  assign gnt_onehot = gnt_valid ? (N'(1) << gnt_idx_q) : '0;
  assign gnt_idx    = gnt_idx_q;
  assign accept     = gnt_valid & gnt_ready;
  assign next_ptr   = (gnt_idx_q == IDW'(N - 1)) ? '0 : gnt_idx_q + IDW'(1);

`ifdef ARB_LOCK_EN
  assign release_gnt = accept & req_last;
`else
  logic unused_req_last;
  assign unused_req_last = req_last;
  assign release_gnt     = accept;
`endif

  always_comb begin
    state_d   = state_q;
    gnt_idx_d = gnt_idx_q;
    rr_ptr_d  = rr_ptr_q;
    cand      = '0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d   = GRANT;
          gnt_idx_d = arb_pick(req, mode, rr_ptr_q);
        end
      end
      GRANT: begin
        if (release_gnt) begin
          rr_ptr_d = next_ptr;
          // The just-accepted requester is excluded so another waiter gets the slot without a bubble.
          cand     = req & ~gnt_onehot;
          if (|cand) begin
            gnt_idx_d = arb_pick(cand, mode, next_ptr);
          end else begin
            state_d   = IDLE;
            gnt_idx_d = '0;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        gnt_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_idx_q <= '0;
      rr_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      gnt_idx_q <= gnt_idx_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

endmodule
